id_branch_unit: RTL and testbench
=================================

Name: id_branch_unit

Overview:
Front half of the Decode stage, sitting on the ID side of the IF/ID interface. Consumes the fetched instruction and its next-PC, and resolves control flow (J, JAL, JR, BEQ, BNE, SYSCALL) in ID. Drives the redirect and stall signals back to Fetch, and registers non-squashed instructions toward Issue. Keeps a register-pending scoreboard so that branch and JR sources are read only once they are valid.

Parameters:
XLEN, 32, datapath/PC width
NREG, 32, architectural registers (r0 hardwired zero)
EXC_VECTOR, 32'h0000_0040, SYSCALL target (selpctype 2'b11; Fetch hardcodes the same value)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
if_id_instruc  in  32  instruction held by Fetch
if_id_nextpc  in  32  PC+4 of that instruction
id_stall  out  1  Fetch holds its outputs and PC
id_if_selpcsource  out  1  redirect Fetch this cycle
id_if_selpctype  out  2  00 branch, 01 register, 10 jump index, 11 exception
id_if_rega  out  32  JR target (rs value)
id_if_pcimd2ext  out  32  branch target
id_if_pcindex  out  32  J/JAL target
id_rs_addr  out  5  regfile read port A address (instr[25:21])
id_rt_addr  out  5  regfile read port B address (instr[20:16])
rf_rs_data  in  32  regfile port A data, combinational
rf_rt_data  in  32  regfile port B data, combinational
iss_stall  in  1  Issue cannot accept
wb_en  in  1  writeback strobe
wb_reg  in  5  writeback register
id_iss_valid  out  1  registered; instruction valid to Issue
id_iss_instruc  out  32  registered instruction
id_iss_nextpc  out  32  registered PC+4

Behaviour:
- Reset (sync): squash=0, scoreboard=0, id_iss_valid=0, id_iss_instruc=0, id_iss_nextpc=0. Combinational outputs settle to 0 because the instruction 0 decodes as a NOP.
- Decode (MIPS encoding):
  - J: op 000010. JAL: op 000011.
  - BEQ: op 000100. BNE: op 000101.
  - JR: op 0 with funct 001000. SYSCALL: op 0 with funct 001100.
- Targets:
  - pcindex = {nextpc[31:28], instr[25:0], 2'b00}.
  - pcimd2ext = nextpc + (signext(instr[15:0]) << 2), mod 2^32 wrap.
  - rega = rf_rs_data.
- Hazard: haz = valid-instruction is BEQ/BNE/JR AND (sb[rs] OR (BEQ/BNE AND sb[rt])). sb[0] is never set.
- id_stall = iss_stall OR haz. When squash=1, only iss_stall counts.
- Redirect, combinational:
  - selpcsource = !squash & !id_stall & (J | JAL | JR | SYSCALL | (BEQ & rs==rt) | (BNE & rs!=rt)).
  - selpctype is driven per the port encoding whenever a control instruction decodes, even if selpcsource=0.
- No delay slot. A redirect in cycle N sets squash at edge N. In cycle N+1 the wrong-path word is dropped: no redirect, no issue, no scoreboard set. squash clears at edge N+1. Taken penalty is 1 bubble.
- Issue register, at each edge:
  - If iss_stall: hold all three outputs.
  - Else: id_iss_valid = !squash & !haz; instruc/nextpc are loaded from the inputs.
  - JAL, JR, J, branches and SYSCALL are all forwarded to Issue. JAL carries nextpc for the link.
- Scoreboard destinations, set at an edge where the issue register loads a valid instruction:
  - R-type rd (op 0, excluding JR and SYSCALL).
  - op 001xxx or 100xxx: rt.
  - JAL: r31.
- Scoreboard clear: on wb_en, clear sb[wb_reg]. If set and clear hit the same register in the same cycle, set wins.
- A stalled redirect never reaches Fetch; Fetch ignores redirects while stalled.

Decomposition:
- Shared package: opcode/funct constants, PCTYPE_BRANCH/REG/INDEX/EXC encodings, EXC_VECTOR, and the destination-select function.
- One sub-module: id_scoreboard (32-bit pending vector; set/clear/lookup on two read ports).

Test Plan:
1. reset=1 for 2 cycles, with stimulus present on the inputs -> all outputs 0, id_stall=0.
2. nextpc=0x0000_0104, instr=0x0800_0010 (J) -> selpcsource=1, selpctype=10, pcindex=0x0000_0040. Next cycle id_iss_valid=0 and no redirect.
3. BEQ r1,r2,imm=0xFFFF, nextpc=0x20, rs=rt=5 -> pcimd2ext=0x0000_001C, type 00, taken. Repeat with BNE -> selpcsource=0 and the instruction issues.
4. ADDI r8 issued, then JR r8 -> id_stall=1 until wb_en with wb_reg=8. The following cycle: redirect type 01, rega=rf_rs_data=0x0000_1000.
5. iss_stall=1 during a taken J -> selpcsource=0, id_stall=1, issue outputs held. On release, the redirect fires once.
6. SYSCALL -> type 11. Assert reset while squash=1 -> squash and scoreboard cleared, and the next instruction issues normally.

Source files
------------

// File: rtl/id_branch_unit_pkg.sv
// Shared decode constants and helpers for the ID-stage branch unit.
// Covers MIPS opcode/funct values, Fetch PC-select encodings and destination selection.
package id_branch_unit_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0040;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    localparam logic [1:0] PCTYPE_BRANCH = 2'b00;
    localparam logic [1:0] PCTYPE_REG    = 2'b01;
    localparam logic [1:0] PCTYPE_INDEX  = 2'b10;
    localparam logic [1:0] PCTYPE_EXC    = 2'b11;

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
    } dest_t;

    // Register an instruction will write; r0 is never reported as pending.
    function automatic dest_t dest_sel(input logic [31:0] instr);
        dest_t      d;
        logic [5:0] op;
        logic [5:0] fn;
        op      = instr[31:26];
        fn      = instr[5:0];
        d.valid = 1'b0;
        d.addr  = 5'd0;
        if (op == OP_SPECIAL) begin
            if ((fn != FN_JR) && (fn != FN_SYSCALL)) begin
                d.valid = 1'b1;
                d.addr  = instr[15:11];
            end else begin
                d.valid = 1'b0;
            end
        end else if ((op[5:3] == 3'b001) || (op[5:3] == 3'b100)) begin
            d.valid = 1'b1;
            d.addr  = instr[20:16];
        end else if (op == OP_JAL) begin
            d.valid = 1'b1;
            d.addr  = 5'd31;
        end else begin
            d.valid = 1'b0;
        end
        if (d.addr == 5'd0) begin
            d.valid = 1'b0;
        end else begin
            d.valid = d.valid;
        end
        return d;
    endfunction

endpackage

// File: rtl/id_branch_unit_if.sv
// IF/ID, regfile, Issue and writeback signals seen by the ID branch unit.
interface id_branch_unit_if;
    import id_branch_unit_pkg::*;

    logic [XLEN-1:0] if_id_instruc;
    logic [XLEN-1:0] if_id_nextpc;
    logic            id_stall;
    logic            id_if_selpcsource;
    logic [1:0]      id_if_selpctype;
    logic [XLEN-1:0] id_if_rega;
    logic [XLEN-1:0] id_if_pcimd2ext;
    logic [XLEN-1:0] id_if_pcindex;
    logic [4:0]      id_rs_addr;
    logic [4:0]      id_rt_addr;
    logic [XLEN-1:0] rf_rs_data;
    logic [XLEN-1:0] rf_rt_data;
    logic            iss_stall;
    logic            wb_en;
    logic [4:0]      wb_reg;
    logic            id_iss_valid;
    logic [XLEN-1:0] id_iss_instruc;
    logic [XLEN-1:0] id_iss_nextpc;

    modport master (
        output if_id_instruc, if_id_nextpc, rf_rs_data, rf_rt_data,
               iss_stall, wb_en, wb_reg,
        input  id_stall, id_if_selpcsource, id_if_selpctype, id_if_rega,
               id_if_pcimd2ext, id_if_pcindex, id_rs_addr, id_rt_addr,
               id_iss_valid, id_iss_instruc, id_iss_nextpc
    );

    modport slave (
        input  if_id_instruc, if_id_nextpc, rf_rs_data, rf_rt_data,
               iss_stall, wb_en, wb_reg,
        output id_stall, id_if_selpcsource, id_if_selpctype, id_if_rega,
               id_if_pcimd2ext, id_if_pcindex, id_rs_addr, id_rt_addr,
               id_iss_valid, id_iss_instruc, id_iss_nextpc
    );

endinterface

// File: rtl/id_branch_unit_scoreboard.sv
// Register-pending vector: set on issue, cleared on writeback, read on two ports.
module id_scoreboard
    import id_branch_unit_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] rs_addr,
    input  logic [4:0] rt_addr,
    output logic       rs_pend,
    output logic       rt_pend
);

    logic [NREG-1:0] sb_r;
    logic [NREG-1:0] sb_next_s;

    // Next pending vector: clear first so a same-register set wins.
    always_comb begin
        sb_next_s = sb_r;
        if (clr_en) begin
            sb_next_s[clr_addr] = 1'b0;
        end else begin
            sb_next_s = sb_next_s;
        end
        if (set_en) begin
            sb_next_s[set_addr] = 1'b1;
        end else begin
            sb_next_s = sb_next_s;
        end
        sb_next_s[0] = 1'b0;
    end

    // Pending-state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            sb_r <= {NREG{1'b0}};
        end else begin
            sb_r <= sb_next_s;
        end
    end

    assign rs_pend = sb_r[rs_addr];
    assign rt_pend = sb_r[rt_addr];

endmodule

// File: rtl/id_branch_unit.sv
// ID-stage control-flow resolution: redirects Fetch, tracks operand hazards,
// and registers non-squashed instructions toward Issue.
module id_branch_unit
    import id_branch_unit_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    id_branch_unit_if.slave  bus
);

    logic [31:0] instr_s;
    logic [31:0] nextpc_s;
    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic        is_j_s, is_jal_s, is_beq_s, is_bne_s, is_jr_s, is_sys_s;
    logic        is_br_s;
    logic        rs_pend_s, rt_pend_s;
    logic        haz_s, stall_s, eq_s, redirect_s, issue_s;
    logic [1:0]  pctype_s;
    dest_t       dest_s;

    logic        squash_r;
    logic        iss_valid_r;
    logic [31:0] iss_instruc_r;
    logic [31:0] iss_nextpc_r;

    assign instr_s  = bus.if_id_instruc;
    assign nextpc_s = bus.if_id_nextpc;
    assign op_s     = instr_s[31:26];
    assign funct_s  = instr_s[5:0];

    assign is_j_s   = (op_s == OP_J);
    assign is_jal_s = (op_s == OP_JAL);
    assign is_beq_s = (op_s == OP_BEQ);
    assign is_bne_s = (op_s == OP_BNE);
    assign is_jr_s  = (op_s == OP_SPECIAL) && (funct_s == FN_JR);
    assign is_sys_s = (op_s == OP_SPECIAL) && (funct_s == FN_SYSCALL);
    assign is_br_s  = is_beq_s | is_bne_s;

    assign dest_s = dest_sel(instr_s);

    id_scoreboard u_sb (
        .clock    (clock),
        .reset    (reset),
        .set_en   (issue_s & dest_s.valid),
        .set_addr (dest_s.addr),
        .clr_en   (bus.wb_en),
        .clr_addr (bus.wb_reg),
        .rs_addr  (instr_s[25:21]),
        .rt_addr  (instr_s[20:16]),
        .rs_pend  (rs_pend_s),
        .rt_pend  (rt_pend_s)
    );

    // The squashed wrong-path word can neither stall nor redirect.
    assign haz_s      = !squash_r & (((is_br_s | is_jr_s) & rs_pend_s) | (is_br_s & rt_pend_s));
    assign stall_s    = bus.iss_stall | haz_s;
    assign eq_s       = (bus.rf_rs_data == bus.rf_rt_data);
    assign redirect_s = !squash_r & !stall_s &
                        (is_j_s | is_jal_s | is_jr_s | is_sys_s |
                         (is_beq_s & eq_s) | (is_bne_s & !eq_s));
    assign issue_s    = !bus.iss_stall & !squash_r & !haz_s;

    // PC-select type from the decoded control instruction.
    always_comb begin
        pctype_s = PCTYPE_BRANCH;
        case (op_s)
            OP_J, OP_JAL: pctype_s = PCTYPE_INDEX;
            OP_SPECIAL: begin
                if (is_jr_s) begin
                    pctype_s = PCTYPE_REG;
                end else if (is_sys_s) begin
                    pctype_s = PCTYPE_EXC;
                end else begin
                    pctype_s = PCTYPE_BRANCH;
                end
            end
            default: pctype_s = PCTYPE_BRANCH;
        endcase
    end

    // Squash the word following any redirect, for exactly one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            squash_r <= 1'b0;
        end else begin
            squash_r <= redirect_s;
        end
    end

    // Issue register, held while Issue back-pressures.
    always_ff @(posedge clock) begin
        if (reset) begin
            iss_valid_r   <= 1'b0;
            iss_instruc_r <= 32'h0000_0000;
            iss_nextpc_r  <= 32'h0000_0000;
        end else if (bus.iss_stall) begin
            iss_valid_r   <= iss_valid_r;
            iss_instruc_r <= iss_instruc_r;
            iss_nextpc_r  <= iss_nextpc_r;
        end else begin
            iss_valid_r   <= !squash_r & !haz_s;
            iss_instruc_r <= instr_s;
            iss_nextpc_r  <= nextpc_s;
        end
    end

    assign bus.id_stall          = stall_s;
    assign bus.id_if_selpcsource = redirect_s;
    assign bus.id_if_selpctype   = pctype_s;
    assign bus.id_if_rega        = bus.rf_rs_data;
    assign bus.id_if_pcimd2ext   = nextpc_s + {{14{instr_s[15]}}, instr_s[15:0], 2'b00};
    assign bus.id_if_pcindex     = {nextpc_s[31:28], instr_s[25:0], 2'b00};
    assign bus.id_rs_addr        = instr_s[25:21];
    assign bus.id_rt_addr        = instr_s[20:16];
    assign bus.id_iss_valid      = iss_valid_r;
    assign bus.id_iss_instruc    = iss_instruc_r;
    assign bus.id_iss_nextpc     = iss_nextpc_r;

endmodule

// File: tb/tb_id_branch_unit.sv
// Directed bench for id_branch_unit; issue-register results go through an expected queue.
module tb_id_branch_unit;
    import id_branch_unit_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    typedef struct packed {
        logic        v;
        logic [31:0] i;
        logic [31:0] n;
    } iss_t;

    iss_t exp_q[$];
    iss_t last_exp;

    id_branch_unit_if bus ();

    id_branch_unit dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    localparam logic [31:0] I_J     = 32'h0800_0010;
    localparam logic [31:0] I_J2    = 32'h0800_0020;
    localparam logic [31:0] I_BEQ   = 32'h1022_FFFF;
    localparam logic [31:0] I_BNE   = 32'h1422_FFFF;
    localparam logic [31:0] I_ADDI8 = 32'h2008_0010;
    localparam logic [31:0] I_ADDI9 = 32'h2009_0000;
    localparam logic [31:0] I_ADDIA = 32'h200A_0000;
    localparam logic [31:0] I_BEQA  = 32'h1140_0001;
    localparam logic [31:0] I_JR8   = 32'h0100_0008;
    localparam logic [31:0] I_JR9   = 32'h0120_0008;
    localparam logic [31:0] I_SYS   = 32'h0000_000C;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic [31:0] i, input logic [31:0] n);
        iss_t e;
        e.v = v;
        e.i = i;
        e.n = n;
        last_exp = e;
        exp_q.push_back(e);
    endtask

    task automatic push_held();
        exp_q.push_back(last_exp);
    endtask

    task automatic tick();
        iss_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("iss_valid", {31'd0, bus.id_iss_valid}, {31'd0, e.v});
            check("iss_instruc", bus.id_iss_instruc, e.i);
            check("iss_nextpc", bus.id_iss_nextpc, e.n);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] n);
        bus.if_id_instruc = i;
        bus.if_id_nextpc  = n;
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic stall, input logic sel, input logic [1:0] typ);
        check({tag, "_stall"}, {31'd0, bus.id_stall}, {31'd0, stall});
        check({tag, "_sel"}, {31'd0, bus.id_if_selpcsource}, {31'd0, sel});
        check({tag, "_type"}, {30'd0, bus.id_if_selpctype}, {30'd0, typ});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst         = 1'b1;
        bus.if_id_instruc = 32'h2004_0001;
        bus.if_id_nextpc  = 32'h0000_0100;
        bus.rf_rs_data    = 32'h0000_0005;
        bus.rf_rt_data    = 32'h0000_0007;
        bus.iss_stall     = 1'b0;
        bus.wb_en         = 1'b0;
        bus.wb_reg        = 5'd0;

        // Reset with live stimulus
        push(1'b0, 32'h0, 32'h0); tick();
        push(1'b0, 32'h0, 32'h0); tick();
        check("rst_stall", {31'd0, bus.id_stall}, 32'd0);
        bus.rf_rs_data = 32'h0;
        bus.rf_rt_data = 32'h0;
        drive(32'h0, 32'h0);
        check_ctl("nop", 1'b0, 1'b0, 2'b00);
        check("nop_pcindex", bus.id_if_pcindex, 32'h0);
        check("nop_pcimd", bus.id_if_pcimd2ext, 32'h0);
        check("nop_rega", bus.id_if_rega, 32'h0);
        rst = 1'b0;

        // J and its squashed successor
        drive(I_J, 32'h0000_0104);
        check_ctl("j", 1'b0, 1'b1, 2'b10);
        check("j_pcindex", bus.id_if_pcindex, 32'h0000_0040);
        push(1'b1, I_J, 32'h0000_0104); tick();
        drive(I_J, 32'h0000_0104);
        check_ctl("j_squash", 1'b0, 1'b0, 2'b10);
        push(1'b0, I_J, 32'h0000_0104); tick();

        // BEQ taken (backward by 4), then BNE during squash, then BNE not taken
        bus.rf_rs_data = 32'd5;
        bus.rf_rt_data = 32'd5;
        drive(I_BEQ, 32'h0000_0020);
        check_ctl("beq_t", 1'b0, 1'b1, 2'b00);
        check("beq_pcimd", bus.id_if_pcimd2ext, 32'h0000_001C);
        push(1'b1, I_BEQ, 32'h0000_0020); tick();
        drive(I_BNE, 32'h0000_0020);
        check("bne_sq_sel", {31'd0, bus.id_if_selpcsource}, 32'd0);
        push(1'b0, I_BNE, 32'h0000_0020); tick();
        drive(I_BNE, 32'h0000_0024);
        check_ctl("bne_nt", 1'b0, 1'b0, 2'b00);
        check("bne_pcimd", bus.id_if_pcimd2ext, 32'h0000_0020);
        push(1'b1, I_BNE, 32'h0000_0024); tick();
        bus.rf_rt_data = 32'd6;
        drive(I_BEQ, 32'h0000_0028);
        check_ctl("beq_nt", 1'b0, 1'b0, 2'b00);
        push(1'b1, I_BEQ, 32'h0000_0028); tick();
        drive(I_BNE, 32'h0000_002C);
        check_ctl("bne_t", 1'b0, 1'b1, 2'b00);
        push(1'b1, I_BNE, 32'h0000_002C); tick();
        drive(32'h0, 32'h0000_0030);
        push(1'b0, 32'h0, 32'h0000_0030); tick();

        // JR waits on r8 until its writeback retires
        drive(I_ADDI8, 32'h0000_0040);
        push(1'b1, I_ADDI8, 32'h0000_0040); tick();
        bus.rf_rs_data = 32'h0000_1000;
        drive(I_JR8, 32'h0000_0044);
        check_ctl("jr_haz1", 1'b1, 1'b0, 2'b01);
        push(1'b0, I_JR8, 32'h0000_0044); tick();
        check("jr_haz2", {31'd0, bus.id_stall}, 32'd1);
        push(1'b0, I_JR8, 32'h0000_0044); tick();
        bus.wb_en  = 1'b1;
        bus.wb_reg = 5'd8;
        #1;
        check("jr_haz_wb", {31'd0, bus.id_stall}, 32'd1);
        push(1'b0, I_JR8, 32'h0000_0044); tick();
        bus.wb_en = 1'b0;
        #1;
        check_ctl("jr_go", 1'b0, 1'b1, 2'b01);
        check("jr_rega", bus.id_if_rega, 32'h0000_1000);
        push(1'b1, I_JR8, 32'h0000_0044); tick();
        drive(32'h0, 32'h0000_0048);
        push(1'b0, 32'h0, 32'h0000_0048); tick();

        // Set and clear of r10 on the same edge: set wins
        bus.wb_en  = 1'b1;
        bus.wb_reg = 5'd10;
        drive(I_ADDIA, 32'h0000_0050);
        push(1'b1, I_ADDIA, 32'h0000_0050); tick();
        bus.wb_en      = 1'b0;
        bus.rf_rs_data = 32'd1;
        bus.rf_rt_data = 32'd2;
        drive(I_BEQA, 32'h0000_0054);
        check_ctl("setwin", 1'b1, 1'b0, 2'b00);
        push(1'b0, I_BEQA, 32'h0000_0054); tick();
        bus.wb_en  = 1'b1;
        bus.wb_reg = 5'd10;
        #1;
        push(1'b0, I_BEQA, 32'h0000_0054); tick();
        bus.wb_en = 1'b0;
        #1;
        check_ctl("setwin_clr", 1'b0, 1'b0, 2'b00);
        push(1'b1, I_BEQA, 32'h0000_0054); tick();

        // Issue back-pressure blocks a taken J and holds the issue register
        bus.iss_stall = 1'b1;
        drive(I_J2, 32'h0000_0200);
        check_ctl("issst_j", 1'b1, 1'b0, 2'b10);
        push_held(); tick();
        push_held(); tick();
        bus.iss_stall = 1'b0;
        #1;
        check_ctl("issrel_j", 1'b0, 1'b1, 2'b10);
        check("issrel_pcindex", bus.id_if_pcindex, 32'h0000_0080);
        push(1'b1, I_J2, 32'h0000_0200); tick();
        check("issrel_once", {31'd0, bus.id_if_selpcsource}, 32'd0);
        push(1'b0, I_J2, 32'h0000_0200); tick();

        // SYSCALL, then reset during its squash cycle
        drive(I_ADDI9, 32'h0000_0300);
        push(1'b1, I_ADDI9, 32'h0000_0300); tick();
        drive(I_SYS, 32'h0000_0304);
        check_ctl("sys", 1'b0, 1'b1, 2'b11);
        push(1'b1, I_SYS, 32'h0000_0304); tick();
        rst = 1'b1;
        drive(I_JR9, 32'h0000_0400);
        push(1'b0, 32'h0, 32'h0); tick();
        rst = 1'b0;
        bus.rf_rs_data = 32'h0000_2222;
        #1;
        check_ctl("post_rst_jr", 1'b0, 1'b1, 2'b01);
        check("post_rst_rega", bus.id_if_rega, 32'h0000_2222);
        push(1'b1, I_JR9, 32'h0000_0400); tick();

        check("q_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
